mem_bus_arb: RTL and testbench
==============================

MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter BURST_LEN, default 4: maximum consecutive accepted dcache transfers that hold priority over the icache.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 i_command  in  BUS_COMMAND  icache request (BUS_NONE = idle, BUS_LOAD only).
REQ-005 i_addr  in  XLEN  icache request address; i_size  in  MEM_SIZE  icache request size.
REQ-006 d_command  in  BUS_COMMAND  dcache request (BUS_NONE, BUS_LOAD or BUS_STORE).
REQ-007 d_addr  in  XLEN, d_size  in  MEM_SIZE, d_data  in  64  dcache address, size and store data.
REQ-008 i_response, d_response  out  4 each  accepted memory tag per requester (0 = not accepted).
REQ-009 i_rsp_tag, d_rsp_tag  out  4 each; i_rsp_data, d_rsp_data  out  64 each  routed load return.
REQ-010 proc2mem_command  out  BUS_COMMAND; proc2mem_addr  out  XLEN; proc2mem_size  out  MEM_SIZE; proc2mem_data  out  64  to memory.
REQ-011 mem2proc_response  in  4; mem2proc_data  in  64; mem2proc_tag  in  4  from memory.
REQ-012 orphan_err  out  1  sticky flag: return tag with no owner.

Function
REQ-013 Requester X is requesting when X_command != BUS_NONE; grant is combinational from inputs and registered state.
REQ-014 Only one requesting: grant it; neither: proc2mem_command = BUS_NONE, proc2mem_addr/size/data = 0.
REQ-015 Both requesting: grant dcache when burst_cnt != 0, else grant the requester other than last_grant.
REQ-016 Granted requester's command/addr/size (dcache also data; icache data = 0) drive proc2mem_* in the same cycle.
REQ-017 Granted requester's X_response = mem2proc_response same cycle; non-granted X_response = 0.
REQ-018 Accepted transfer = grant with mem2proc_response != 0; last_grant updates to the granted requester only on accepted transfers.
REQ-019 burst_cnt (log2(BURST_LEN) bits): accepted dcache transfer -> burst_cnt = (burst_cnt == BURST_LEN-1) ? 0 : burst_cnt+1; cycle with d_command == BUS_NONE -> 0; otherwise hold.
REQ-020 Owner table, 15 entries indexed by tag 1..15: valid bit plus owner id (I/D).
REQ-021 Accepted BUS_LOAD sets entry[mem2proc_response] valid with owner = granted requester; accepted BUS_STORE records nothing.
REQ-022 mem2proc_tag != 0 with entry valid: owner's X_rsp_tag = mem2proc_tag, X_rsp_data = mem2proc_data same cycle; other requester sees tag 0, data 0; entry cleared next edge.
REQ-023 mem2proc_tag == 0: both rsp_tag = 0, rsp_data = 0.
REQ-024 mem2proc_tag != 0 with entry invalid: dropped (both rsp_tag 0), orphan_err set next edge, held until rst.
REQ-025 Same-cycle retire and allocate of the same tag: allocation wins (entry valid, new owner); routing of the returning data uses the old owner.
REQ-026 Allocation of a tag whose entry is already valid (not retiring) overwrites owner; no error.
REQ-027 No combinational path from mem2proc_tag to proc2mem_*.

Reset
REQ-028 On rst: all owner entries invalid, burst_cnt = 0, last_grant = icache (dcache wins first contest), orphan_err = 0.
REQ-029 rst mid-burst or with tags outstanding discards all state; returns arriving after rst are orphans and set orphan_err.
REQ-030 With rst high and no requests, all outputs are 0 / BUS_NONE.

Verification
REQ-031 After rst, both issue BUS_LOAD, mem response 1 -> d_response = 1, i_response = 0, proc2mem_addr = d_addr.
REQ-032 Both request continuously, memory always accepts, BURST_LEN=4 -> grant pattern D,D,D,D,I,D,D,D,D,I.
REQ-033 icache load accepted with tag 5, later mem2proc_tag = 5, data 0xDEADBEEF_00C0FFEE -> i_rsp_tag = 5 with that data, d_rsp_tag = 0; next return of tag 5 sets orphan_err.
REQ-034 dcache BUS_STORE accepted with tag 3 -> no entry; mem2proc_tag = 3 later -> orphan_err = 1.
REQ-035 Tag 7 returning to dcache while icache load accepted as tag 7 same cycle -> d_rsp_tag = 7 this cycle; subsequent tag 7 return routes to icache.
REQ-036 Memory rejects (response 0) for 3 cycles with both requesting -> grant, last_grant and burst_cnt unchanged; first acceptance goes to same requester.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared memory-bus types for the cache-to-memory arbiter.
//   XLEN        - address width
//   BUS_COMMAND - bus command encoding (none / load / store)
//   MEM_SIZE    - transfer size encoding
package mem_bus_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        MEM_BYTE   = 2'h0,
        MEM_HALF   = 2'h1,
        MEM_WORD   = 2'h2,
        MEM_DOUBLE = 2'h3
    } MEM_SIZE;

endpackage

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: arbitrates a single memory port between an icache (loads only)
// and a dcache (loads and stores), and routes tagged load returns back to
// whichever requester issued them.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_command/i_addr/i_size       icache request
//   d_command/d_addr/d_size/d_data dcache request (d_data is store data)
//   i_response, d_response        memory tag accepted for that requester (0 = none)
//   i_rsp_tag/i_rsp_data          load return routed to the icache
//   d_rsp_tag/d_rsp_data          load return routed to the dcache
//   proc2mem_*                    request presented to memory
//   mem2proc_response             tag accepted by memory this cycle (0 = rejected)
//   mem2proc_data/mem2proc_tag    load return from memory
//   orphan_err                    sticky: a return tag arrived with no owner
//
// The dcache may hold the port for up to BURST_LEN consecutive accepted
// transfers while the icache is also requesting; otherwise contests alternate.
module mem_bus_arb
    import mem_bus_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  BUS_COMMAND        i_command,
    input  logic [XLEN-1:0]   i_addr,
    input  MEM_SIZE           i_size,

    input  BUS_COMMAND        d_command,
    input  logic [XLEN-1:0]   d_addr,
    input  MEM_SIZE           d_size,
    input  logic [63:0]       d_data,

    output logic [3:0]        i_response,
    output logic [3:0]        d_response,
    output logic [3:0]        i_rsp_tag,
    output logic [63:0]       i_rsp_data,
    output logic [3:0]        d_rsp_tag,
    output logic [63:0]       d_rsp_data,

    output BUS_COMMAND        proc2mem_command,
    output logic [XLEN-1:0]   proc2mem_addr,
    output MEM_SIZE           proc2mem_size,
    output logic [63:0]       proc2mem_data,

    input  logic [3:0]        mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [3:0]        mem2proc_tag,

    output logic              orphan_err
);

    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Registered state
    owner_e         last_q, last_d;
    logic [CW-1:0]  burst_q, burst_d;
    logic [15:0]    valid_q, valid_d;   // entry 0 never becomes valid
    owner_e         owner_q [16];
    owner_e         owner_d [16];
    logic           orphan_q, orphan_d;

    grant_e         grant;
    logic           i_req, d_req;
    logic           accepted;
    logic           ret_hit;

    assign i_req = (i_command != BUS_NONE);
    assign d_req = (d_command != BUS_NONE);

    // Grant selection: dcache keeps the port mid-burst, otherwise the
    // requester that did not win the last accepted transfer goes first.
    always_comb begin
        grant = GNT_NONE;
        if (i_req && d_req) begin
            if (burst_q != '0)
                grant = GNT_D;
            else
                grant = (last_q == OWN_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end
    end

    // Memory request mux and acceptance responses
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_size    = MEM_BYTE;
        proc2mem_data    = '0;
        i_response       = '0;
        d_response       = '0;
        case (grant)
            GNT_I: begin
                proc2mem_command = i_command;
                proc2mem_addr    = i_addr;
                proc2mem_size    = i_size;
                i_response       = mem2proc_response;
            end
            GNT_D: begin
                proc2mem_command = d_command;
                proc2mem_addr    = d_addr;
                proc2mem_size    = d_size;
                proc2mem_data    = d_data;
                d_response       = mem2proc_response;
            end
            default: ;
        endcase
    end

    // Return routing uses the table as it stood before this edge, so a tag
    // re-allocated in the same cycle still delivers to its previous owner.
    assign ret_hit = (mem2proc_tag != '0) && valid_q[mem2proc_tag];

    always_comb begin
        i_rsp_tag  = '0;
        i_rsp_data = '0;
        d_rsp_tag  = '0;
        d_rsp_data = '0;
        if (ret_hit) begin
            if (owner_q[mem2proc_tag] == OWN_I) begin
                i_rsp_tag  = mem2proc_tag;
                i_rsp_data = mem2proc_data;
            end else begin
                d_rsp_tag  = mem2proc_tag;
                d_rsp_data = mem2proc_data;
            end
        end
    end

    assign accepted = (grant != GNT_NONE) && (mem2proc_response != '0);

    // Next-state: last grant, burst counter, owner table, orphan flag
    always_comb begin
        last_d   = last_q;
        burst_d  = burst_q;
        valid_d  = valid_q;
        owner_d  = owner_q;
        orphan_d = orphan_q;

        if (accepted)
            last_d = (grant == GNT_D) ? OWN_D : OWN_I;

        if (accepted && grant == GNT_D)
            burst_d = (burst_q == CW'(BURST_LEN - 1)) ? '0 : burst_q + CW'(1);
        else if (!d_req)
            burst_d = '0;

        // Retire first, then allocate, so allocation of the same tag wins.
        if (mem2proc_tag != '0) begin
            if (valid_q[mem2proc_tag])
                valid_d[mem2proc_tag] = 1'b0;
            else
                orphan_d = 1'b1;
        end

        if (accepted && proc2mem_command == BUS_LOAD) begin
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = (grant == GNT_D) ? OWN_D : OWN_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= OWN_I;
            burst_q  <= '0;
            valid_q  <= '0;
            orphan_q <= 1'b0;
            for (int unsigned k = 0; k < 16; k++)
                owner_q[k] <= OWN_I;
        end else begin
            last_q   <= last_d;
            burst_q  <= burst_d;
            valid_q  <= valid_d;
            orphan_q <= orphan_d;
            owner_q  <= owner_d;
        end
    end

    assign orphan_err = orphan_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed bench for mem_bus_arb with a behavioural reference
// model compared on every falling clock edge, plus literal expectations for
// the key arbitration and tag-routing scenarios.
module tb_mem_bus_arb;
    import mem_bus_pkg::*;

    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst;
    BUS_COMMAND      i_command, d_command;
    logic [XLEN-1:0] i_addr, d_addr;
    MEM_SIZE         i_size, d_size;
    logic [63:0]     d_data;
    logic [3:0]      i_response, d_response, i_rsp_tag, d_rsp_tag;
    logic [63:0]     i_rsp_data, d_rsp_data;
    BUS_COMMAND      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    MEM_SIZE         proc2mem_size;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response, mem2proc_tag;
    logic [63:0]     mem2proc_data;
    logic            orphan_err;

    always #5 clk = ~clk;

    mem_bus_arb #(.BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .i_command(i_command), .i_addr(i_addr), .i_size(i_size),
        .d_command(d_command), .d_addr(d_addr), .d_size(d_size), .d_data(d_data),
        .i_response(i_response), .d_response(d_response),
        .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data),
        .d_rsp_tag(d_rsp_tag), .d_rsp_data(d_rsp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag), .orphan_err(orphan_err)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // who: 0 = icache, 1 = dcache. m_streak counts consecutive accepted
    // dcache transfers since the dcache last went idle.
    bit m_init = 0;
    int m_last;
    int m_streak;
    bit m_valid [16];
    int m_owner [16];
    bit m_orphan;

    always @(negedge clk) begin : model_cmp
        int g;
        bit ireq, dreq, acc;
        logic [1:0]  ecmd, esize;
        logic [63:0] eaddr, edata, eir, edr, eit, edt, eid, edd;

        ireq = (i_command != BUS_NONE);
        dreq = (d_command != BUS_NONE);
        g = 0;
        if (ireq && dreq) begin
            if (m_streak % BL != 0) g = 2;
            else g = (m_last == 0) ? 2 : 1;
        end else if (dreq) g = 2;
        else if (ireq) g = 1;

        ecmd = 2'(BUS_NONE); esize = 0; eaddr = 0; edata = 0; eir = 0; edr = 0;
        if (g == 1) begin
            ecmd = i_command; esize = i_size; eaddr = 64'(i_addr); eir = 64'(mem2proc_response);
        end else if (g == 2) begin
            ecmd = d_command; esize = d_size; eaddr = 64'(d_addr); edata = d_data;
            edr = 64'(mem2proc_response);
        end
        eit = 0; edt = 0; eid = 0; edd = 0;
        if (mem2proc_tag != 0 && m_valid[mem2proc_tag]) begin
            if (m_owner[mem2proc_tag] == 0) begin eit = 64'(mem2proc_tag); eid = mem2proc_data; end
            else begin edt = 64'(mem2proc_tag); edd = mem2proc_data; end
        end

        if (m_init) begin
            check("proc2mem_command", 64'(proc2mem_command), 64'(ecmd));
            check("proc2mem_addr", 64'(proc2mem_addr), eaddr);
            check("proc2mem_size", 64'(proc2mem_size), 64'(esize));
            check("proc2mem_data", proc2mem_data, edata);
            check("i_response", 64'(i_response), eir);
            check("d_response", 64'(d_response), edr);
            check("i_rsp_tag", 64'(i_rsp_tag), eit);
            check("i_rsp_data", i_rsp_data, eid);
            check("d_rsp_tag", 64'(d_rsp_tag), edt);
            check("d_rsp_data", d_rsp_data, edd);
            check("orphan_err", 64'(orphan_err), 64'(m_orphan));
        end

        // state seen after the upcoming rising edge
        if (rst) begin
            m_init = 1; m_last = 0; m_streak = 0; m_orphan = 0;
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else begin
            acc = (g != 0) && (mem2proc_response != 0);
            if (acc) m_last = g - 1;
            if (acc && g == 2) m_streak++;
            else if (!dreq) m_streak = 0;
            if (mem2proc_tag != 0) begin
                if (m_valid[mem2proc_tag]) m_valid[mem2proc_tag] = 0;
                else m_orphan = 1;
            end
            if (acc && ecmd == 2'(BUS_LOAD)) begin
                m_valid[mem2proc_response] = 1;
                m_owner[mem2proc_response] = g - 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        i_command = BUS_NONE; d_command = BUS_NONE;
        i_addr = '0; d_addr = '0; i_size = MEM_WORD; d_size = MEM_WORD; d_data = '0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); next(); rst = 1'b0;
    endtask

    initial begin : stim
        string pat;
        byte   got;

        rst = 1'b1; idle();
        next(); next();
        // reset with no requests: everything quiet
        settle();
        check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_addr", 64'(proc2mem_addr), 64'h0);
        check("rst_dresp", 64'(d_response), 64'h0);
        check("rst_irsp_tag", 64'(i_rsp_tag), 64'h0);
        check("rst_orphan", 64'(orphan_err), 64'h0);
        next(); rst = 1'b0;

        // both load continuously, memory always accepts
        pat = "DDDDIDDDDI";
        i_command = BUS_LOAD; d_command = BUS_LOAD;
        i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_data = 64'hD0;
        for (int k = 0; k < 10; k++) begin
            mem2proc_response = 4'(k + 1);
            settle();
            if (k == 0) begin
                check("first_dresp", 64'(d_response), 64'h1);
                check("first_iresp", 64'(i_response), 64'h0);
                check("first_addr", 64'(proc2mem_addr), 64'h2000);
            end
            got = (d_response != 0) ? "D" : (i_response != 0) ? "I" : "-";
            check("burst_pattern", 64'(got), 64'(pat[k]));
            next();
        end
        // tag 5 belongs to the icache now
        idle(); next();
        mem2proc_tag = 4'd5; mem2proc_data = 64'hDEADBEEF_00C0FFEE;
        settle();
        check("ret5_itag", 64'(i_rsp_tag), 64'h5);
        check("ret5_idata", i_rsp_data, 64'hDEADBEEF_00C0FFEE);
        check("ret5_dtag", 64'(d_rsp_tag), 64'h0);
        next();
        settle();
        check("ret5_again_itag", 64'(i_rsp_tag), 64'h0);
        check("ret5_again_orphan_pre", 64'(orphan_err), 64'h0);
        next(); idle();
        settle();
        check("ret5_orphan", 64'(orphan_err), 64'h1);
        next(); idle(); next();
        settle();
        check("orphan_sticky", 64'(orphan_err), 64'h1);
        next();

        // dcache store records no owner
        do_reset();
        settle();
        check("post_rst_orphan", 64'(orphan_err), 64'h0);
        next();
        d_command = BUS_STORE; d_addr = 32'h0000_3000; d_size = MEM_DOUBLE;
        d_data = 64'h1122_3344_5566_7788; mem2proc_response = 4'd3;
        settle();
        check("store_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        check("store_data", proc2mem_data, 64'h1122_3344_5566_7788);
        check("store_dresp", 64'(d_response), 64'h3);
        next(); idle(); mem2proc_tag = 4'd3; mem2proc_data = 64'h33;
        settle();
        check("store_ret_dtag", 64'(d_rsp_tag), 64'h0);
        check("store_ret_itag", 64'(i_rsp_tag), 64'h0);
        next(); idle();
        settle();
        check("store_orphan", 64'(orphan_err), 64'h1);
        next();

        // same-cycle retire (dcache) and allocate (icache) of tag 7
        do_reset();
        d_command = BUS_LOAD; d_addr = 32'h0000_4000; mem2proc_response = 4'd7;
        next(); idle();
        i_command = BUS_LOAD; i_addr = 32'h0000_5000; mem2proc_response = 4'd7;
        mem2proc_tag = 4'd7; mem2proc_data = 64'hAAAA;
        settle();
        check("t7_dtag", 64'(d_rsp_tag), 64'h7);
        check("t7_ddata", d_rsp_data, 64'hAAAA);
        check("t7_itag", 64'(i_rsp_tag), 64'h0);
        check("t7_iresp", 64'(i_response), 64'h7);
        next(); idle(); mem2proc_tag = 4'd7; mem2proc_data = 64'hBBBB;
        settle();
        check("t7b_itag", 64'(i_rsp_tag), 64'h7);
        check("t7b_dtag", 64'(d_rsp_tag), 64'h0);
        next(); idle();
        settle();
        check("t7_no_orphan", 64'(orphan_err), 64'h0);
        next();

        // memory rejects: grant, history and burst count must not move
        do_reset();
        i_command = BUS_LOAD; d_command = BUS_LOAD;
        i_addr = 32'h0000_6000; d_addr = 32'h0000_7000;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rej_dresp", 64'(d_response), 64'h0);
            check("rej_addr_d", 64'(proc2mem_addr), 64'h7000);
            next();
        end
        mem2proc_response = 4'd2;
        settle();
        check("rej_then_dresp", 64'(d_response), 64'h2);
        next();
        // drop the dcache for a cycle (burst count clears, icache rejected)
        d_command = BUS_NONE; mem2proc_response = 4'd0;
        next();
        d_command = BUS_LOAD;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("rej_addr_i", 64'(proc2mem_addr), 64'h6000);
            next();
        end
        mem2proc_response = 4'd4;
        settle();
        check("rej_then_iresp", 64'(i_response), 64'h4);
        next();

        // reset with tags outstanding turns their returns into orphans
        do_reset();
        mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
        settle();
        check("rst_out_dtag", 64'(d_rsp_tag), 64'h0);
        next(); idle();
        settle();
        check("rst_out_orphan", 64'(orphan_err), 64'h1);
        next();

        // mixed traffic checked by the model alone
        do_reset();
        for (int k = 0; k < 80; k++) begin
            i_command = ($urandom_range(0, 3) != 0) ? BUS_LOAD : BUS_NONE;
            d_command = BUS_COMMAND'($urandom_range(0, 2));
            i_addr = $urandom; d_addr = $urandom;
            i_size = MEM_SIZE'($urandom_range(0, 3));
            d_size = MEM_SIZE'($urandom_range(0, 3));
            d_data = {$urandom, $urandom};
            mem2proc_response = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            mem2proc_tag = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            mem2proc_data = {$urandom, $urandom};
            next();
        end
        idle();
        next(); next();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
